// File: rtl/dl_deserializer.sv
// dl_deserializer
//   Recovers a framed serial stream into a parallel row/column buffer.
//   A frame is: dl_en rises, PREAMBLE_COUNT alternating training bits, then
//   (depth+1) rows of (width+1) bits each, row 0 first, MSB (bit index
//   width) first within a row. Each bit lasts clk_div+1 clk cycles and is
//   sampled at the middle of its period.
//
//   The transmitter must drop dl_en between frames. While dl_en stays high
//   after a completed or rejected frame, the receiver waits in WAIT_IDLE and
//   does not re-arm.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   dl_in         serial data, synchronous to clk
//   dl_en         line-active qualifier from the transmitter
//   clk_div       bit period minus one, in clk cycles
//   width, depth  row bits minus one / rows minus one (clamped to maximum)
//   par_out       last successfully received frame
//   out_valid     one-cycle pulse when par_out is updated
//   busy          receiver is not idle
//   preamble_err  one-cycle pulse: training pattern violated
//   frame_err     one-cycle pulse: dl_en dropped mid-frame
//   dbg_state     current FSM state (0 IDLE, 1 PREAMBLE, 2 PAYLOAD, 3 WAIT_IDLE)
module dl_deserializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_DEPTH     = 4,
  parameter int DIV_WIDTH      = 8,
  parameter int PREAMBLE_COUNT = 8,
  localparam int WW  = $clog2(DATA_WIDTH) + 1,
  localparam int DW  = $clog2(DATA_DEPTH) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  dl_in,
  input  logic                                  dl_en,
  input  logic [DIV_WIDTH-1:0]                  clk_div,
  input  logic [WW-1:0]                         width,
  input  logic [DW-1:0]                         depth,
  output logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_out,
  output logic                                  out_valid,
  output logic                                  busy,
  output logic                                  preamble_err,
  output logic                                  frame_err,
  output logic [1:0]                            dbg_state
);

  localparam int PCW = $clog2(PREAMBLE_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PREAMBLE  = 2'd1,
    PAYLOAD   = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  state_t                               state_q, state_d;
  logic [DIV_WIDTH-1:0]                 phase_q, phase_d;
  logic [PCW-1:0]                       pre_cnt_q, pre_cnt_d;
  logic                                 exp_q, exp_d;
  logic [DW-1:0]                        row_q, row_d;
  logic [WW-1:0]                        col_q, col_d;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_out_q, par_out_d;
  logic                                 out_valid_q, out_valid_d;
  logic                                 preamble_err_q, preamble_err_d;
  logic                                 frame_err_q, frame_err_d;

  logic [WW-1:0] width_eff;
  logic [DW-1:0] depth_eff;
  logic          wrap;
  logic          sample;
  logic          mismatch;

  // Out-of-range geometry is clamped to the buffer size.
  assign width_eff = (width > WW'(DATA_WIDTH - 1)) ? WW'(DATA_WIDTH - 1) : width;
  assign depth_eff = (depth > DW'(DATA_DEPTH - 1)) ? DW'(DATA_DEPTH - 1) : depth;

  // Mid-bit sampling; with clk_div=0 both conditions hold every cycle.
  assign wrap   = (phase_q == clk_div);
  assign sample = (phase_q == (clk_div >> 1));

  // The first training sample only seeds the expectation.
  assign mismatch = (pre_cnt_q != '0) && (dl_in != exp_q);

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    pre_cnt_d      = pre_cnt_q;
    exp_d          = exp_q;
    row_d          = row_q;
    col_d          = col_q;
    shadow_d       = shadow_q;
    par_out_d      = par_out_q;
    out_valid_d    = 1'b0;
    preamble_err_d = 1'b0;
    frame_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (dl_en) begin
          state_d   = PREAMBLE;
          pre_cnt_d = '0;
          row_d     = '0;
          col_d     = width_eff;
          shadow_d  = '0;
        end
      end

      PREAMBLE: begin
        phase_d = wrap ? '0 : phase_q + 1'b1;
        // Losing dl_en outranks a simultaneous pattern mismatch.
        if (!dl_en) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
          shadow_d    = '0;
        end else if (sample && mismatch) begin
          preamble_err_d = 1'b1;
          state_d        = WAIT_IDLE;
        end else begin
          if (sample) begin
            exp_d     = ~dl_in;
            pre_cnt_d = pre_cnt_q + 1'b1;
          end
          // Payload starts on a bit boundary once training is complete.
          if (wrap && (pre_cnt_d == PCW'(PREAMBLE_COUNT))) begin
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        phase_d = wrap ? '0 : phase_q + 1'b1;
        if (!dl_en) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
          shadow_d    = '0;
        end else if (sample) begin
          for (int r = 0; r < DATA_DEPTH; r++) begin
            for (int c = 0; c < DATA_WIDTH; c++) begin
              if ((int'(row_q) == r) && (int'(col_q) == c)) begin
                shadow_d[r][c] = dl_in;
              end
            end
          end
          if (col_q == '0) begin
            if (row_q == depth_eff) begin
              // Publish including the bit captured this cycle.
              par_out_d   = shadow_d;
              out_valid_d = 1'b1;
              state_d     = WAIT_IDLE;
            end else begin
              row_d = row_q + 1'b1;
              col_d = width_eff;
            end
          end else begin
            col_d = col_q - 1'b1;
          end
        end
      end

      WAIT_IDLE: begin
        phase_d = '0;
        if (!dl_en) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      pre_cnt_q      <= '0;
      exp_q          <= 1'b0;
      row_q          <= '0;
      col_q          <= '0;
      shadow_q       <= '0;
      par_out_q      <= '0;
      out_valid_q    <= 1'b0;
      preamble_err_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      pre_cnt_q      <= pre_cnt_d;
      exp_q          <= exp_d;
      row_q          <= row_d;
      col_q          <= col_d;
      shadow_q       <= shadow_d;
      par_out_q      <= par_out_d;
      out_valid_q    <= out_valid_d;
      preamble_err_q <= preamble_err_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign par_out      = par_out_q;
  assign out_valid    = out_valid_q;
  assign preamble_err = preamble_err_q;
  assign frame_err    = frame_err_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dl_deserializer.sv
module tb_dl_deserializer;

  localparam int DATA_WIDTH = 8;
  localparam int DATA_DEPTH = 4;
  localparam int DIV_WIDTH  = 8;

  logic                                  clk;
  logic                                  rst;
  logic                                  dl_in;
  logic                                  dl_en;
  logic [DIV_WIDTH-1:0]                  clk_div;
  logic [3:0]                            width;
  logic [2:0]                            depth;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_out;
  logic                                  out_valid;
  logic                                  busy;
  logic                                  preamble_err;
  logic                                  frame_err;
  logic [1:0]                            dbg_state;

  int tests;
  int fails;
  int ov_cnt;
  int pe_cnt;
  int fe_cnt;
  int excl_cnt;

  dl_deserializer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .DATA_DEPTH    (DATA_DEPTH),
    .DIV_WIDTH     (DIV_WIDTH),
    .PREAMBLE_COUNT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dl_in       (dl_in),
    .dl_en       (dl_en),
    .clk_div     (clk_div),
    .width       (width),
    .depth       (depth),
    .par_out     (par_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .preamble_err(preamble_err),
    .frame_err   (frame_err),
    .dbg_state   (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitors (count high cycles, sampled on the falling edge)
  always @(negedge clk) begin
    if (out_valid)    ov_cnt = ov_cnt + 1;
    if (preamble_err) pe_cnt = pe_cnt + 1;
    if (frame_err)    fe_cnt = fe_cnt + 1;
    if ((int'(out_valid) + int'(preamble_err) + int'(frame_err)) > 1) excl_cnt = excl_cnt + 1;
  end

  // driver tasks
  task automatic clear_counts();
    ov_cnt = 0;
    pe_cnt = 0;
    fe_cnt = 0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    dl_en = 1'b0;
    dl_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int div);
    dl_in = b;
    repeat (div + 1) @(negedge clk);
  endtask

  // Raise dl_en (one IDLE cycle) and send the 1010... training bits.
  task automatic send_preamble(input int div, input int nbits);
    @(negedge clk);
    dl_en = 1'b1;
    dl_in = 1'b0;
    @(negedge clk);
    for (int i = 0; i < nbits; i++) drive_bit(((i % 2) == 0), div);
  endtask

  task automatic send_payload(input int div, input logic [63:0] pay, input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(pay[nbits-1-i], div);
  endtask

  task automatic end_frame();
    dl_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (par_out !== 32'h0) begin fails++; $display("FAIL reset_par_out got=%h exp=%h", par_out, 32'h0); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (preamble_err !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL reset_errs got=%b%b exp=00", preamble_err, frame_err); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_frame_div3();
    clear_counts();
    clk_div = 8'd3; width = 4'd7; depth = 3'd1;
    send_preamble(3, 8);
    send_payload(3, 64'hA53C, 16);
    tests++; if (busy !== 1'b1 || dbg_state !== 2'd3) begin fails++; $display("FAIL div3_wait_idle got busy=%b state=%0d exp busy=1 state=3", busy, dbg_state); end
    end_frame();
    tests++; if (par_out !== 32'h00003CA5) begin fails++; $display("FAIL div3_par_out got=%h exp=%h", par_out, 32'h00003CA5); end
    tests++; if (ov_cnt !== 1) begin fails++; $display("FAIL div3_out_valid_cycles got=%0d exp=1", ov_cnt); end
    tests++; if (pe_cnt !== 0 || fe_cnt !== 0) begin fails++; $display("FAIL div3_no_errs got pe=%0d fe=%0d exp 0 0", pe_cnt, fe_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL div3_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_frame_div0();
    do_reset();
    clear_counts();
    clk_div = 8'd0; width = 4'd7; depth = 3'd1;
    send_preamble(0, 8);
    send_payload(0, 64'hA53C, 16);
    // one clock after the last sample edge
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL div0_valid_timing got=%b exp=1", out_valid); end
    tests++; if (par_out !== 32'h00003CA5) begin fails++; $display("FAIL div0_par_out got=%h exp=%h", par_out, 32'h00003CA5); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL div0_valid_drop got=%b exp=0", out_valid); end
    end_frame();
    tests++; if (ov_cnt !== 1) begin fails++; $display("FAIL div0_valid_cycles got=%0d exp=1", ov_cnt); end
  endtask

  task automatic test_preamble_err();
    clear_counts();
    clk_div = 8'd0;
    send_preamble(0, 3);
    dl_in = 1'b1;       // 4th training bit should have been 0
    @(negedge clk);
    tests++; if (preamble_err !== 1'b1) begin fails++; $display("FAIL pre_err_pulse got=%b exp=1", preamble_err); end
    tests++; if (dbg_state !== 2'd3) begin fails++; $display("FAIL pre_err_state got=%0d exp=3", dbg_state); end
    @(negedge clk);
    tests++; if (preamble_err !== 1'b0) begin fails++; $display("FAIL pre_err_drop got=%b exp=0", preamble_err); end
    repeat (6) drive_bit(1'b0, 0);
    end_frame();
    tests++; if (par_out !== 32'h00003CA5) begin fails++; $display("FAIL pre_err_par_kept got=%h exp=%h", par_out, 32'h00003CA5); end
    tests++; if (ov_cnt !== 0 || fe_cnt !== 0 || pe_cnt !== 1) begin fails++; $display("FAIL pre_err_counts got ov=%0d fe=%0d pe=%0d exp 0 0 1", ov_cnt, fe_cnt, pe_cnt); end
  endtask

  task automatic test_frame_err();
    clear_counts();
    clk_div = 8'd3; width = 4'd7; depth = 3'd1;
    send_preamble(3, 8);
    send_payload(3, 64'h1F, 5);
    dl_en = 1'b0;
    @(negedge clk);
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL frame_err_pulse got=%b exp=1", frame_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL frame_err_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    tests++; if (par_out !== 32'h00003CA5) begin fails++; $display("FAIL frame_err_par_kept got=%h exp=%h", par_out, 32'h00003CA5); end
    tests++; if (fe_cnt !== 1 || ov_cnt !== 0 || pe_cnt !== 0) begin fails++; $display("FAIL frame_err_counts got fe=%0d ov=%0d pe=%0d exp 1 0 0", fe_cnt, ov_cnt, pe_cnt); end
  endtask

  task automatic test_wait_idle();
    clear_counts();
    clk_div = 8'd1; width = 4'd3; depth = 3'd0;
    send_preamble(1, 8);
    send_payload(1, 64'hB, 4);
    // line stays up, toggling like a fresh preamble: must be ignored
    for (int i = 0; i < 20; i++) begin
      dl_in = ((i % 2) == 0);
      @(negedge clk);
    end
    tests++; if (busy !== 1'b1 || dbg_state !== 2'd3) begin fails++; $display("FAIL wait_idle_hold got busy=%b state=%0d exp 1 3", busy, dbg_state); end
    tests++; if (par_out !== 32'h0000000B) begin fails++; $display("FAIL wait_idle_par got=%h exp=%h", par_out, 32'h0000000B); end
    tests++; if (ov_cnt !== 1 || pe_cnt !== 0) begin fails++; $display("FAIL wait_idle_single got ov=%0d pe=%0d exp 1 0", ov_cnt, pe_cnt); end
    end_frame();
    send_preamble(1, 8);
    send_payload(1, 64'h6, 4);
    end_frame();
    tests++; if (par_out !== 32'h00000006 || ov_cnt !== 2) begin fails++; $display("FAIL wait_idle_rearm got par=%h ov=%0d exp 00000006 2", par_out, ov_cnt); end
  endtask

  task automatic test_clamp();
    clear_counts();
    clk_div = 8'd1; width = 4'd15; depth = 3'd7;
    send_preamble(1, 8);
    send_payload(1, 64'h11223344, 32);
    end_frame();
    tests++; if (par_out !== 32'h44332211) begin fails++; $display("FAIL clamp_par got=%h exp=%h", par_out, 32'h44332211); end
    tests++; if (ov_cnt !== 1) begin fails++; $display("FAIL clamp_valid got=%0d exp=1", ov_cnt); end
  endtask

  task automatic test_rst_mid();
    clear_counts();
    clk_div = 8'd3; width = 4'd7; depth = 3'd1;
    send_preamble(3, 8);
    send_payload(3, 64'h15, 5);
    #2 rst = 1'b1;
    #1;
    tests++; if (par_out !== 32'h0 || busy !== 1'b0 || out_valid !== 1'b0 || preamble_err !== 1'b0 || frame_err !== 1'b0) begin
      fails++; $display("FAIL rst_mid_outputs got par=%h busy=%b ov=%b pe=%b fe=%b exp all 0", par_out, busy, out_valid, preamble_err, frame_err);
    end
    @(negedge clk);
    rst   = 1'b0;
    dl_en = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (ov_cnt !== 0 || pe_cnt !== 0 || fe_cnt !== 0) begin fails++; $display("FAIL rst_mid_no_pulse got ov=%0d pe=%0d fe=%0d exp 0 0 0", ov_cnt, pe_cnt, fe_cnt); end
    send_preamble(3, 8);
    send_payload(3, 64'hA53C, 16);
    end_frame();
    tests++; if (par_out !== 32'h00003CA5 || ov_cnt !== 1) begin fails++; $display("FAIL rst_mid_recover got par=%h ov=%0d exp 00003CA5 1", par_out, ov_cnt); end
  endtask

  // sequence + report
  initial begin
    tests    = 0;
    fails    = 0;
    excl_cnt = 0;
    clear_counts();
    rst     = 1'b1;
    dl_in   = 1'b0;
    dl_en   = 1'b0;
    clk_div = 8'd3;
    width   = 4'd7;
    depth   = 3'd1;

    test_reset();
    test_frame_div3();
    test_frame_div0();
    test_preamble_err();
    test_frame_err();
    test_wait_idle();
    test_clamp();
    test_rst_mid();

    tests++; if (excl_cnt !== 0) begin fails++; $display("FAIL pulse_exclusive got=%0d exp=0", excl_cnt); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // hard stop in case anything stalls
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
